// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dpram stream reader.
//   state_t    : reader FSM state encoding
//   FIFO_*     : output FIFO geometry (depth 4, 2-bit pointers, 3-bit count)
package dpram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_PTR_W = 2;
   localparam int FIFO_CNT_W = 3;

endpackage

// File: rtl/stream_fifo4.sv
// 4-entry synchronous FIFO for the reader output stream.
// Ports:
//   clk, reset_n        : clock, async active-low reset (clears pointers/count)
//   push, push_data     : write request and word
//   pop, pop_data       : read request and head word (zero when empty)
//   count, full, empty  : occupancy status
module stream_fifo4
   import dpram_stream_reader_pkg::*;
#(
   parameter int w = 9
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [w-1:0]          push_data,
   input  logic                  pop,
   output logic [w-1:0]          pop_data,
   output logic [FIFO_CNT_W-1:0] count,
   output logic                  full,
   output logic                  empty
);

   logic [w-1:0]          mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Head is forced to zero when empty so the stream outputs read as 0 after reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side engine for a dpram buffer: walks port-B addresses from start_addr
// for length words (wrapping mod 2^aw), absorbs the one-cycle read latency and
// presents the words as a valid/ready stream with m_last on the final word.
// Ports:
//   clk, reset_n               : clock (also dpram clkb), async active-low reset
//   start, start_addr, length  : transfer request, sampled only while idle
//   addrb, doutb               : dpram port B address / read data
//   m_data, m_valid, m_ready, m_last : output stream
//   busy, done                 : transfer in progress, one-cycle completion pulse
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; first fetch issues on the accepting edge
// ST_RUN   | issuing one fetch per cycle while words remain and credit allows
// ST_DRAIN | all fetched; waiting for pipeline and FIFO to empty, then done
module dpram_stream_reader
   import dpram_stream_reader_pkg::*;
#(
   parameter int aw = 8,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [aw-1:0] start_addr,
   input  logic [aw:0]   length,
   output logic [aw-1:0] addrb,
   input  logic [dw-1:0] doutb,
   output logic [dw-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy,
   output logic          done
);

   state_t                state;
   state_t                state_nxt;
   logic [aw-1:0]         addr;
   logic [aw:0]           remaining;
   logic                  s1_vld;
   logic                  s1_last;
   logic                  s2_vld;
   logic                  s2_last;
   logic                  fetch;
   logic                  fetch_last;
   logic                  done_nxt;
   logic [aw-1:0]         fetch_addr;
   logic [aw:0]           rem_base;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic [dw:0]           fifo_head;
   logic [3:0]            occupancy;
   logic                  credit_ok;

   // Every issued fetch owns a FIFO slot until it is popped, so the FIFO
   // can never overflow whatever m_ready does.
   assign occupancy = {1'b0, fifo_count} + {3'b0, s1_vld} + {3'b0, s2_vld};
   assign credit_ok = !fifo_full && (occupancy < 4'(FIFO_DEPTH));

   // The accepting edge in IDLE issues the first fetch directly from the
   // request, which puts start_addr on addrb in the cycle after start.
   assign fetch_addr = (state == ST_IDLE) ? start_addr : addr;
   assign rem_base   = (state == ST_IDLE) ? length : remaining;

   always_comb begin
      state_nxt  = state;
      fetch      = 1'b0;
      fetch_last = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  fetch      = 1'b1;
                  fetch_last = (length == (aw+1)'(1));
                  state_nxt  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (remaining == '0) begin
               state_nxt = ST_DRAIN;
            end else if (credit_ok) begin
               fetch      = 1'b1;
               fetch_last = (remaining == (aw+1)'(1));
               if (fetch_last) state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!s1_vld && !s2_vld &&
                (fifo_empty || (fifo_count == FIFO_CNT_W'(1) && pop))) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         remaining <= '0;
         addrb     <= '0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s2_vld    <= 1'b0;
         s2_last   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state   <= state_nxt;
         done    <= done_nxt;
         s1_vld  <= fetch;
         s1_last <= fetch & fetch_last;
         s2_vld  <= s1_vld;
         s2_last <= s1_last;
         if (fetch) begin
            addrb     <= fetch_addr;
            addr      <= fetch_addr + 1'b1;
            remaining <= rem_base - 1'b1;
         end
      end
   end

   // s2 lines up with doutb, so only words we actually fetched are captured.
   stream_fifo4 #(.w(dw + 1)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (s2_vld),
      .push_data ({s2_last, doutb}),
      .pop       (pop),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m_valid = ~fifo_empty;
   assign pop     = m_valid & m_ready;
   assign m_data  = fifo_head[dw-1:0];
   assign m_last  = fifo_head[dw];
   assign busy    = (state != ST_IDLE);

endmodule
